// File: rtl/shift_pipe_pkg.sv
// rtl/shift_pipe_pkg.sv - shared constants, delay legalisation and popcount helpers
package shift_pipe_pkg;

  localparam int SHIFT_PIPE_MAX_SUPPORTED = 64;
  localparam int LEG_W = $clog2(SHIFT_PIPE_MAX_SUPPORTED + 1);

  typedef struct packed {
    logic [LEG_W-1:0] dly;
    logic             err;
  } dly_leg_t;

  // Out-of-range requests fall back to the deepest tap and raise the error bit.
  function automatic dly_leg_t legalise_dly(input logic [LEG_W-1:0] req,
                                            input logic [LEG_W-1:0] max_depth);
    dly_leg_t res;
    if (req == '0 || req > max_depth) begin
      res.dly = max_depth;
      res.err = 1'b1;
    end else begin
      res.dly = req;
      res.err = 1'b0;
    end
    return res;
  endfunction

  function automatic logic [LEG_W-1:0] popcount(input logic [SHIFT_PIPE_MAX_SUPPORTED-1:0] v);
    logic [LEG_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < SHIFT_PIPE_MAX_SUPPORTED; i++) begin
      cnt = cnt + LEG_W'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/shift_pipe_mc_if.sv
// rtl/shift_pipe_mc_if.sv - data/control bundle between a producer and the delay line
interface shift_pipe_mc_if #(
  parameter int WIDTH     = 8,
  parameter int CHANNELS  = 2,
  parameter int MAX_DEPTH = 4
);
  localparam int DLY_W = $clog2(MAX_DEPTH + 1);

  logic                      i_en;
  logic                      i_flush;
  logic                      i_valid;
  logic [CHANNELS*WIDTH-1:0] i_data;
  logic [DLY_W-1:0]          i_dly;
  logic                      o_valid;
  logic [CHANNELS*WIDTH-1:0] o_data;
  logic [DLY_W-1:0]          o_occ;
  logic                      o_empty;
  logic                      o_dly_err;

  modport master (
    output i_en, i_flush, i_valid, i_data, i_dly,
    input  o_valid, o_data, o_occ, o_empty, o_dly_err
  );

  modport slave (
    input  i_en, i_flush, i_valid, i_data, i_dly,
    output o_valid, o_data, o_occ, o_empty, o_dly_err
  );
endinterface

// File: rtl/shift_pipe_lane.sv
// rtl/shift_pipe_lane.sv - one WIDTH-bit lane: MAX_DEPTH stages with enable and tap mux
// Optional stage export under SHIFT_PIPE_TAPS_EN.
module shift_pipe_lane #(
  parameter int WIDTH     = 8,
  parameter int MAX_DEPTH = 4,
  parameter int DLY_W     = 3
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_en,
  input  logic [WIDTH-1:0]           i_data,
  input  logic [DLY_W-1:0]           i_tap_sel,
  output logic [WIDTH-1:0]           o_tap
`ifdef SHIFT_PIPE_TAPS_EN
  ,
  output logic [MAX_DEPTH*WIDTH-1:0] o_stages
`endif
);

  logic [WIDTH-1:0] stage_q [MAX_DEPTH];
  logic [WIDTH-1:0] stage_d [MAX_DEPTH];

  always_comb begin
    stage_d = stage_q;
    if (i_en) begin
      stage_d[0] = i_data;
      for (int k = 1; k < MAX_DEPTH; k++) begin
        stage_d[k] = stage_q[k-1];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < MAX_DEPTH; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  always_comb begin
    o_tap = '0;
    for (int k = 0; k < MAX_DEPTH; k++) begin
      if (DLY_W'(k) == i_tap_sel) o_tap = stage_q[k];
    end
  end

`ifdef SHIFT_PIPE_TAPS_EN
  for (genvar k = 0; k < MAX_DEPTH; k++) begin : g_stage_out
    assign o_stages[k*WIDTH +: WIDTH] = stage_q[k];
  end
`endif

endmodule

// File: rtl/shift_pipe_mc.sv
// rtl/shift_pipe_mc.sv - multi-channel delay line with valid tracking, stall, flush and tunable tap
// Define SHIFT_PIPE_TAPS_EN to expose every stage on o_taps/o_tap_valid.
module shift_pipe_mc
  import shift_pipe_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CHANNELS  = 2,
  parameter int MAX_DEPTH = 4
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  shift_pipe_mc_if.slave                      bus
`ifdef SHIFT_PIPE_TAPS_EN
  ,
  output logic [MAX_DEPTH*CHANNELS*WIDTH-1:0] o_taps,
  output logic [MAX_DEPTH-1:0]                o_tap_valid
`endif
);

  localparam int DLY_W = $clog2(MAX_DEPTH + 1);

  logic [MAX_DEPTH-1:0]                v_q, v_d;
  logic [DLY_W-1:0]                    dly_q, dly_d;
  logic [DLY_W-1:0]                    occ_q, occ_d;
  logic                                empty_q, empty_d;
  logic                                err_q, err_d;
  logic [DLY_W-1:0]                    tap_sel;
  logic                                retune;
  dly_leg_t                            leg;
  logic [SHIFT_PIPE_MAX_SUPPORTED-1:0] v_win;

  always_comb begin
    leg    = legalise_dly(LEG_W'(bus.i_dly), LEG_W'(MAX_DEPTH));
    dly_d  = DLY_W'(leg.dly);
    err_d  = err_q | leg.err;
    retune = (dly_d != dly_q);

    // Flush beats retune; retune clears history but keeps the incoming sample.
    v_d = v_q;
    if (bus.i_flush) begin
      v_d = '0;
    end else if (retune) begin
      v_d = '0;
      if (bus.i_en) v_d[0] = bus.i_valid;
    end else if (bus.i_en) begin
      for (int k = MAX_DEPTH - 1; k > 0; k--) begin
        v_d[k] = v_q[k-1];
      end
      v_d[0] = bus.i_valid;
    end

    v_win = '0;
    for (int k = 0; k < MAX_DEPTH; k++) begin
      if (DLY_W'(k) < dly_d) v_win[k] = v_d[k];
    end
    occ_d   = DLY_W'(popcount(v_win));
    empty_d = (occ_d == '0);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v_q     <= '0;
      dly_q   <= DLY_W'(MAX_DEPTH);
      occ_q   <= '0;
      empty_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      v_q     <= v_d;
      dly_q   <= dly_d;
      occ_q   <= occ_d;
      empty_q <= empty_d;
      err_q   <= err_d;
    end
  end

  assign tap_sel = dly_q - DLY_W'(1);

  always_comb begin
    bus.o_valid = 1'b0;
    for (int k = 0; k < MAX_DEPTH; k++) begin
      if (DLY_W'(k) == tap_sel) bus.o_valid = v_q[k];
    end
  end

  assign bus.o_occ     = occ_q;
  assign bus.o_empty   = empty_q;
  assign bus.o_dly_err = err_q;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
`ifdef SHIFT_PIPE_TAPS_EN
    logic [MAX_DEPTH*WIDTH-1:0] stages;
`endif
    shift_pipe_lane #(
      .WIDTH     (WIDTH),
      .MAX_DEPTH (MAX_DEPTH),
      .DLY_W     (DLY_W)
    ) u_lane (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_en      (bus.i_en),
      .i_data    (bus.i_data[c*WIDTH +: WIDTH]),
      .i_tap_sel (tap_sel),
      .o_tap     (bus.o_data[c*WIDTH +: WIDTH])
`ifdef SHIFT_PIPE_TAPS_EN
      ,
      .o_stages  (stages)
`endif
    );
`ifdef SHIFT_PIPE_TAPS_EN
    for (genvar k = 0; k < MAX_DEPTH; k++) begin : g_tap
      assign o_taps[k*CHANNELS*WIDTH + c*WIDTH +: WIDTH] = stages[k*WIDTH +: WIDTH];
    end
`endif
  end

`ifdef SHIFT_PIPE_TAPS_EN
  assign o_tap_valid = v_q;
`endif

endmodule
